// File: rtl/gon_mcc_buf_pkg.sv
// gon_pkg: shared types, constants and the ID/mask match helper for the
// GON multicast controller slice.
// Optional feature macro used by gon_mcc_buf: GON_MCC_BCAST_EN.
package gon_pkg;

    // Default tag width of the GON; modules may be built narrower or wider.
    localparam int GON_TAG_W   = 4;
    // Widest tag the match helper handles; narrower tags are zero-extended.
    localparam int GON_TAG_MAX = 64;

    typedef logic [GON_TAG_W-1:0] tag_t;

    // All-ones tag reserved for broadcast; slice to the instance tag width.
    localparam logic [GON_TAG_MAX-1:0] GON_BCAST_TAG = '1;

    // A tag hits when every bit not marked don't-care in mask equals the ID.
    // Zero-extension of all three operands leaves the upper bits neutral.
    function automatic logic gon_tag_match(input logic [GON_TAG_MAX-1:0] tag,
                                           input logic [GON_TAG_MAX-1:0] id,
                                           input logic [GON_TAG_MAX-1:0] mask);
        return ((tag ^ id) & ~mask) == '0;
    endfunction

endpackage

// File: rtl/gon_mcc_buf_if.sv
// gon_mcc_buf_if: bus-side ingress (data/tag/enable/ready) and consumer-side
// egress (data/enable/ready) handshake of the multicast controller.
// master = bus segment plus consumer, slave = the controller itself.
interface gon_mcc_buf_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  in_enable;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_enable;
    logic                  out_ready;

    modport master (
        output in_data, in_tag, in_enable, out_ready,
        input  in_ready, out_data, out_enable
    );

    modport slave (
        input  in_data, in_tag, in_enable, out_ready,
        output in_ready, out_data, out_enable
    );
endinterface

// File: rtl/gon_mcc_buf_fifo.sv
// gon_fifo: synchronous first-word-fall-through FIFO. The head word is
// visible on rdata whenever the FIFO is non-empty and reads as zero when
// empty. DEPTH must be a power of two so the pointers wrap for free.
// The caller guarantees no push when full and no pop when empty.
module gon_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         count;

    // Pointers and occupancy; reset flushes the FIFO without touching storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are only meaningful behind the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gon_mcc_buf.sv
// gon_mcc_buf: buffered multicast controller for the global-on-chip network.
// Claims bus words whose tag matches the loaded ID/mask, queues them in a
// DEPTH-entry FWFT FIFO and hands them downstream on a ready/enable
// handshake. Words not addressed here always see in_ready=1.
// Build option: define GON_MCC_BCAST_EN to let the all-ones tag hit every
// configured controller.
module gon_mcc_buf
    import gon_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_load,
    input  logic [TAG_WIDTH-1:0] cfg_id,
    input  logic [TAG_WIDTH-1:0] cfg_mask,
    gon_mcc_buf_if.slave         bus,
    output logic                 cfg_valid,
    output logic [LW-1:0]        fifo_level
);

    logic [TAG_WIDTH-1:0]   q_id;
    logic [TAG_WIDTH-1:0]   q_mask;

    logic [GON_TAG_MAX-1:0] tag_x;
    logic [GON_TAG_MAX-1:0] id_x;
    logic [GON_TAG_MAX-1:0] mask_x;
    logic                   id_hit;
    logic                   bcast_hit;
    logic                   match;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    // Config registers; a reload takes effect for matching on the next cycle
    // and leaves already-queued words alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_id      <= '1;
            q_mask    <= '0;
            cfg_valid <= 1'b0;
        end else if (cfg_load) begin
            q_id      <= cfg_id;
            q_mask    <= cfg_mask;
            cfg_valid <= 1'b1;
        end
    end

    assign tag_x  = GON_TAG_MAX'(bus.in_tag);
    assign id_x   = GON_TAG_MAX'(q_id);
    assign mask_x = GON_TAG_MAX'(q_mask);
    assign id_hit = gon_tag_match(tag_x, id_x, mask_x);

`ifdef GON_MCC_BCAST_EN
    assign bcast_hit = (bus.in_tag == GON_BCAST_TAG[TAG_WIDTH-1:0]);
`else
    assign bcast_hit = 1'b0;
`endif

    // An unconfigured controller never claims a word, broadcast or not.
    assign match = cfg_valid & (id_hit | bcast_hit);

    // Only a full FIFO facing a word addressed here can hold the bus; out_ready
    // deliberately plays no part, so a full FIFO never accepts on a pop.
    assign bus.in_ready = ~match | ~full;

    assign push = bus.in_enable & match & ~full;
    assign pop  = ~empty & bus.out_ready;

    gon_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (bus.out_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign bus.out_enable = ~empty;

endmodule

// File: tb/tb_gon_mcc_buf.sv
// tb_gon_mcc_buf: randomized and directed stimulus for gon_mcc_buf, with a
// queue-based reference model updated at each clock edge and a monitor that
// compares the DUT against the model on every falling edge.
module tb_gon_mcc_buf;
    import gon_pkg::*;

    localparam int DW = 64;
    localparam int TW = 4;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          cfg_load;
    logic [TW-1:0] cfg_id;
    logic [TW-1:0] cfg_mask;
    logic          cfg_valid;
    logic [LW-1:0] fifo_level;

    gon_mcc_buf_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    gon_mcc_buf #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_id     (cfg_id),
        .cfg_mask   (cfg_mask),
        .bus        (bus),
        .cfg_valid  (cfg_valid),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_cfg_valid;
    tag_t          m_id;
    tag_t          m_mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Specification-level match: configured, and every non-ignored bit equal.
    function automatic bit m_match(input tag_t t);
        if (!m_cfg_valid) return 1'b0;
`ifdef GON_MCC_BCAST_EN
        if (t == 4'hF) return 1'b1;
`endif
        for (int b = 0; b < TW; b++)
            if (!m_mask[b] && (t[b] != m_id[b])) return 1'b0;
        return 1'b1;
    endfunction

    // Model update at each edge: pop head if taken, append claimed words.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_cfg_valid = 1'b0;
            m_id        = '1;
            m_mask      = '0;
        end else begin
            bit acc, tk;
            acc = bus.in_enable && m_match(bus.in_tag) && (mq.size() < DEPTH);
            tk  = (mq.size() > 0) && bus.out_ready;
            if (tk) void'(mq.pop_front());
            if (acc) mq.push_back(bus.in_data);
            if (cfg_load) begin
                m_id        = cfg_id;
                m_mask      = cfg_mask;
                m_cfg_valid = 1'b1;
            end
        end
    end

    // Monitor: compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_enable", 64'(bus.out_enable), 64'(mq.size() != 0));
            chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
            chk("cfg_valid", 64'(cfg_valid), 64'(m_cfg_valid));
            chk("in_ready", 64'(bus.in_ready),
                64'(!(m_match(bus.in_tag) && mq.size() == DEPTH)));
            if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
            else                chk("out_data_empty", bus.out_data, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input tag_t id, input tag_t mask);
        cfg_load = 1'b1; cfg_id = id; cfg_mask = mask;
        step();
        cfg_load = 1'b0;
    endtask

    // Present one word and hold it until the controller is not blocking it.
    task automatic send(input tag_t tag, input logic [DW-1:0] data);
        logic r;
        bus.in_enable = 1'b1; bus.in_tag = tag; bus.in_data = data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                bus.in_enable = 1'b0;
                return;
            end
        end
        bus.in_enable = 1'b0;
        n_checks++;
        $display("FAIL send_timeout: tag %0h still held after 20 cycles, required accept", tag);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tagname, "_out_enable"}, 64'(bus.out_enable), 64'd0);
        chk({tagname, "_out_data"}, bus.out_data, 64'd0);
        chk({tagname, "_level"}, 64'(fifo_level), 64'd0);
        chk({tagname, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_id = '0; cfg_mask = '0;
        bus.in_enable = 1'b1; bus.in_tag = 4'h5; bus.in_data = '0; bus.out_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        step(); step();
        check_reset_outputs("por2");
        reset = 1'b0;

        // Unconfigured: every tag passes by, nothing is stored
        for (int i = 0; i < 4; i++) begin
            bus.in_tag = 4'($urandom); bus.in_data = {$urandom, $urandom};
            step();
        end
        bus.in_enable = 1'b0;

        // Exact ID: tag 5 claimed, tag 6 ignored
        do_cfg(4'h5, 4'h0);
        send(4'h5, 64'hAAAA_0000_0000_000A);
        send(4'h6, 64'hBBBB_0000_0000_000B);
        step(); step();

        // Masked ID: 4..7 claimed in order, 8 ignored
        do_cfg(4'h4, 4'h3);
        for (int t = 4; t <= 8; t++) send(4'(t), 64'(t) | 64'hD000_0000_0000_0000);
        step(); step();

        // Fill to DEPTH, hold fifth word, then release
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(4'(4 + i), 64'h1000 + 64'(i));
        chk("full_level", 64'(fifo_level), 64'(DEPTH));
        bus.in_enable = 1'b1; bus.in_tag = 4'h5; bus.in_data = 64'h5555;
        step(); step();
        bus.out_ready = 1'b1;
        step();
        step();
        bus.in_enable = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Steady push+pop at level 2
        bus.out_ready = 1'b0;
        send(4'h4, 64'h2000);
        send(4'h5, 64'h2001);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(4'(4 + (i % 4)), 64'h3000 + 64'(i));
        chk("steady_level", 64'(fifo_level), 64'd2);

        // Reset in mid-stream
        bus.in_enable = 1'b1; bus.in_tag = 4'h6; bus.in_data = 64'h4444;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        step();
        reset = 1'b0;
        bus.in_enable = 1'b0;
        step();

        // All-ones tag against id 5
        do_cfg(4'h5, 4'h0);
        bus.in_enable = 1'b1; bus.in_tag = 4'hF; bus.in_data = 64'hFFFF_0000;
        step();
        bus.in_enable = 1'b0;
`ifdef GON_MCC_BCAST_EN
        chk("bcast_level", 64'(fifo_level), 64'd1);
`else
        chk("bcast_level", 64'(fifo_level), 64'd0);
`endif
        step(); step();

        // Randomized traffic with occasional reconfiguration
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                cfg_load = 1'b1; cfg_id = 4'($urandom); cfg_mask = 4'($urandom & 32'h5);
            end else begin
                cfg_load = 1'b0;
            end
            bus.in_enable = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus.in_tag = 4'hF;
                1, 2:    bus.in_tag = m_id ^ (4'($urandom) & m_mask);
                default: bus.in_tag = 4'($urandom);
            endcase
            bus.in_data = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        cfg_load = 1'b0;
        bus.in_enable = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        chk("drained_level", 64'(fifo_level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gon_mcc_buf.md
# gon_mcc_buf

Buffered, parametrised multicast controller for the global-on-chip network (GON). Sits between a GON bus segment and one consumer (PE or next-level bus). It claims bus words whose tag matches a run-time-configured ID/mask pair, queues them in a DEPTH-entry first-word-fall-through FIFO, and hands them downstream with a ready/enable handshake. Its in_ready term never stalls traffic that is not addressed to it.

## Interface
- DATA_WIDTH, 64, payload width
- TAG_WIDTH, 4, tag/ID width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge only
- reset  in  1  reset, asynchronous, active-high
- cfg_load  in  1  load cfg_id/cfg_mask this cycle
- cfg_id  in  TAG_WIDTH  controller ID
- cfg_mask  in  TAG_WIDTH  don't-care bits of ID (1 = ignore bit)
- in_data  in  DATA_WIDTH  bus payload
- in_tag  in  TAG_WIDTH  destination tag of bus word
- in_enable  in  1  bus word valid
- in_ready  out  1  this controller does not block the bus word
- out_data  out  DATA_WIDTH  FIFO head; zero when empty
- out_enable  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts head
- cfg_valid  out  1  ID has been loaded since reset
- fifo_level  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Config registers: q_id, q_mask, cfg_valid. On cfg_load: q_id←cfg_id, q_mask←cfg_mask, cfg_valid←1. New values are used for matching from the next cycle. Reload mid-traffic is legal; queued FIFO contents are unaffected.
- match = cfg_valid & (((in_tag ^ q_id) & ~q_mask) == 0). It is combinational on the registered config.
- in_ready = ~match | ~full. The term is independent of out_ready, so there is no full-pop bypass.
- push = in_enable & match & ~full. pop = out_enable & out_ready.
- Non-matching words: in_ready=1 and nothing is stored.
- Matching word while full: in_ready=0, so the bus holds the word. The word is never dropped.
- push & pop in the same cycle, FIFO neither empty nor full: level unchanged, order preserved.
- push & pop with FIFO empty: pop is impossible (out_enable=0), so the word enters the FIFO.
- Pointers wrap modulo DEPTH. The level saturates at neither end because the handshake prevents overflow and underflow.
- Reset (at any time, including mid-transfer): q_id=all-ones, q_mask=0, cfg_valid=0, FIFO flushed. Output values under reset: out_enable=0, out_data=0, fifo_level=0, in_ready=1 (no match is possible while unconfigured).

## Timing
- Accept-to-output latency: a word pushed at edge N appears on out_data with out_enable=1 after edge N, i.e. in cycle N+1.
- Full throughput: one push and one pop per cycle sustained.
- in_ready is combinational from in_tag and the registered config/full flag. There is no path from out_ready to in_ready.
- out_data and out_enable are driven from registers and FIFO storage. There is no combinational path from the in_* ports.

## Configuration
- GON_MCC_BCAST_EN defined: an in_tag of all-ones matches every controller with cfg_valid=1, regardless of q_id/q_mask.
- Undefined: an all-ones tag is matched like any other tag, by ID/mask only.
- Unconfigured controllers (cfg_valid=0) never match, with or without the macro.

## Structure
- Package gon_pkg holds:
  - tag_t typedef (TAG_WIDTH bits)
  - the GON_BCAST_TAG constant (all-ones)
  - a helper function for the ID/mask match
- One sub-module, gon_fifo: synchronous FWFT FIFO with push, pop, full, empty and level outputs, parametrised on DATA_WIDTH and DEPTH.
- gon_mcc_buf contains the config registers, match logic and handshake glue.

## Test plan
- Reset then in_enable=1 with any tag → in_ready=1, out_enable=0, fifo_level=0, cfg_valid=0.
- cfg_load id=4'h5, mask=4'h0; send tags 5 and 6 with data A and B → only A appears one cycle after its accept; tag 6 sees in_ready=1 and no push.
- mask=4'h3, id=4'h4; tags 4, 5, 6, 7 accepted and tag 8 ignored → out_data order is 4, 5, 6, 7 data.
- out_ready=0, push DEPTH=4 matching words → fifo_level=4. Fifth matching word sees in_ready=0 and is held. Raise out_ready → head pops, fifth word is accepted on the following edge, and ordering is intact.
- Simultaneous push/pop at level 2 over 10 cycles → fifo_level stays 2 and data is FIFO-ordered. Assert reset mid-stream → outputs return to reset values within the same cycle and cfg_valid=0.
- GON_MCC_BCAST_EN on: tag 4'hF with id=5 is accepted. Macro off: the same stimulus is not accepted and in_ready=1.
